pet2001io_sched: RTL and testbench

- Cycle scheduler and arbiter for the PET I/O register block (PIA1, PIA2, VIA at 0xE800-0xEFFF).
- Divides the fast system clock into 6502 bus cycles and emits the CPU clock enable and the VIA timer tick.
- Time-shares the single I/O register port between the CPU and a host debug port (memory-mapped monitor/UART bridge), giving each its own fixed slot per bus cycle.
- Captures I/O read data one clock after each access, matching the registered read mux in the I/O block.

---
 rtl/pet2001io_sched.sv | 161 ++++++++++++++++
 tb/tb_pet2001io_sched.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pet2001io_sched.sv
// PET I/O bus-cycle scheduler: divides clk into 6502 bus cycles, emits
// cpu_rdy / slow_clock, and time-shares the I/O register port between
// the CPU (last count of each bus cycle) and a host debug port
// (HOST_SLOT). Read data is captured one clock after each access.
// Ports: clk/reset; cpu_* CPU side; host_* debug side with req/ack
// handshake; io_* to the PIA/VIA register block; slow_clock VIA tick.
module pet2001io_sched #(
    parameter int CLK_DIV   = 50,
    parameter int HOST_SLOT = CLK_DIV / 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [10:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    input  logic        cpu_we,
    input  logic        cpu_sel,
    input  logic        cpu_halt,
    output logic        cpu_rdy,
    output logic [7:0]  cpu_rdata,
    input  logic        host_req,
    input  logic        host_we,
    input  logic [10:0] host_addr,
    input  logic [7:0]  host_wdata,
    output logic        host_ack,
    output logic [7:0]  host_rdata,
    output logic        host_busy,
    output logic [10:0] io_addr,
    output logic [7:0]  io_wdata,
    output logic        io_we,
    output logic        io_rdy,
    input  logic [7:0]  io_rdata,
    output logic        slow_clock
);

    if (CLK_DIV < 4 || CLK_DIV > 255) begin : g_bad_div
        $error("CLK_DIV must be in 4..255");
    end
    if (HOST_SLOT < 1 || HOST_SLOT > CLK_DIV - 3) begin : g_bad_slot
        $error("HOST_SLOT must be in 1..CLK_DIV-3");
    end

    localparam logic [7:0] LAST  = 8'(CLK_DIV - 1);
    localparam logic [7:0] HSLOT = 8'(HOST_SLOT);

    typedef enum logic [1:0] {
        IDLE,
        PEND,
        CAPT
    } hstate_t;

    hstate_t     state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        slow_q, slow_d;
    logic        busy_q, busy_d;
    logic        ack_q, ack_d;
    logic        h_we_q, h_we_d;
    logic [10:0] h_addr_q, h_addr_d;
    logic [7:0]  h_wdata_q, h_wdata_d;
    logic        cpu_cap_q, cpu_cap_d;
    logic [7:0]  cpu_rdata_q, cpu_rdata_d;
    logic [7:0]  host_rdata_q, host_rdata_d;

    logic cpu_slot;
    logic host_slot;
    logic host_go;
    logic cpu_go;

    // Slot decode and I/O port mux
    always_comb begin
        cpu_slot  = (cnt_q == LAST);
        host_slot = (cnt_q == HSLOT);
        host_go   = (state_q == PEND) && host_slot;
        cpu_go    = cpu_slot && cpu_sel && !cpu_halt;

        cpu_rdy  = cpu_slot && !cpu_halt;
        io_rdy   = host_go || cpu_go;
        io_we    = host_go ? h_we_q : (cpu_go && cpu_we);
        io_addr  = host_go ? h_addr_q : cpu_addr;
        io_wdata = host_go ? h_wdata_q : cpu_wdata;

        // Host read data passes straight through during the ack clock
        // so it is valid alongside host_ack, then is held.
        host_rdata = (ack_q && !h_we_q) ? io_rdata : host_rdata_q;
    end

    // Next-state logic
    always_comb begin
        cnt_d        = cpu_slot ? 8'd0 : cnt_q + 8'd1;
        slow_d       = (cnt_d == LAST);
        cpu_cap_d    = cpu_go && !cpu_we;
        cpu_rdata_d  = cpu_cap_q ? io_rdata : cpu_rdata_q;
        host_rdata_d = host_rdata;

        state_d   = state_q;
        busy_d    = busy_q;
        ack_d     = 1'b0;
        h_we_d    = h_we_q;
        h_addr_d  = h_addr_q;
        h_wdata_d = h_wdata_q;

        unique case (state_q)
            IDLE: begin
                if (host_req) begin
                    h_we_d    = host_we;
                    h_addr_d  = host_addr;
                    h_wdata_d = host_wdata;
                    busy_d    = 1'b1;
                    state_d   = PEND;
                end
            end
            PEND: begin
                if (host_slot) begin
                    ack_d   = 1'b1;
                    state_d = CAPT;
                end
            end
            CAPT: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= 8'd0;
            slow_q       <= 1'b0;
            busy_q       <= 1'b0;
            ack_q        <= 1'b0;
            h_we_q       <= 1'b0;
            h_addr_q     <= 11'd0;
            h_wdata_q    <= 8'd0;
            cpu_cap_q    <= 1'b0;
            cpu_rdata_q  <= 8'd0;
            host_rdata_q <= 8'd0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            slow_q       <= slow_d;
            busy_q       <= busy_d;
            ack_q        <= ack_d;
            h_we_q       <= h_we_d;
            h_addr_q     <= h_addr_d;
            h_wdata_q    <= h_wdata_d;
            cpu_cap_q    <= cpu_cap_d;
            cpu_rdata_q  <= cpu_rdata_d;
            host_rdata_q <= host_rdata_d;
        end
    end

    assign slow_clock = slow_q;
    assign host_busy  = busy_q;
    assign host_ack   = ack_q;
    assign cpu_rdata  = cpu_rdata_q;

endmodule

// File: tb/tb_pet2001io_sched.sv
// Self-checking bench for pet2001io_sched (CLK_DIV=8, HOST_SLOT=4).
// Cycle-indexed reference model plus directed and random stimulus.
module tb_pet2001io_sched;

    localparam int DIV  = 8;
    localparam int HS   = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [10:0] cpu_addr = '0;
    logic [7:0]  cpu_wdata = '0;
    logic        cpu_we = 1'b0;
    logic        cpu_sel = 1'b0;
    logic        cpu_halt = 1'b0;
    logic        cpu_rdy;
    logic [7:0]  cpu_rdata;
    logic        host_req = 1'b0;
    logic        host_we = 1'b0;
    logic [10:0] host_addr = '0;
    logic [7:0]  host_wdata = '0;
    logic        host_ack;
    logic [7:0]  host_rdata;
    logic        host_busy;
    logic [10:0] io_addr;
    logic [7:0]  io_wdata;
    logic        io_we;
    logic        io_rdy;
    logic [7:0]  io_rdata = '0;
    logic        slow_clock;

    pet2001io_sched #(.CLK_DIV(DIV), .HOST_SLOT(HS)) dut (
        .clk(clk), .reset(reset),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_we(cpu_we),
        .cpu_sel(cpu_sel), .cpu_halt(cpu_halt), .cpu_rdy(cpu_rdy),
        .cpu_rdata(cpu_rdata),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
        .host_wdata(host_wdata), .host_ack(host_ack),
        .host_rdata(host_rdata), .host_busy(host_busy),
        .io_addr(io_addr), .io_wdata(io_wdata), .io_we(io_we),
        .io_rdy(io_rdy), .io_rdata(io_rdata), .slow_clock(slow_clock)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    // I/O block emulation memory and the model's own copy
    logic [7:0] iomem [2048];
    logic [7:0] refmem [2048];

    // Model state: cycle index since reset release and host transaction
    int          k;
    int          h_lat, h_acc, h_ack;
    logic        h_we;
    logic [10:0] h_addr;
    logic [7:0]  h_wd, h_val;
    int          cpu_due;
    logic [7:0]  cpu_val;
    logic [7:0]  m_crd, m_hrd;

    // Observation counters and snapshots for directed checks
    int n_slow, n_crdy, n_iordy, n_ack, n_busy;
    int         s_c;
    logic       s_io_rdy, s_io_we, s_ack;
    logic [10:0] s_io_addr;
    logic [7:0] s_io_wdata, s_cpu_rdata, s_host_rdata;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     nm, act, exp, k);
        end
    endtask

    task automatic zero_counts();
        n_slow = 0; n_crdy = 0; n_iordy = 0; n_ack = 0; n_busy = 0;
    endtask

    task automatic model_reset();
        k = 0;
        h_lat = -100; h_acc = -100; h_ack = -100;
        cpu_due = -100;
        m_crd = 8'h00; m_hrd = 8'h00;
    endtask

    task automatic set_idle();
        cpu_sel = 1'b0; cpu_we = 1'b0; cpu_halt = 1'b0;
        host_req = 1'b0; host_we = 1'b0;
    endtask

    // Called at posedge+1 with the cycle's inputs driven; returns at the
    // next posedge+1 with k advanced.
    task automatic run_cycle();
        int c;
        logic e_busy, e_ack, hacc, cacc, e_rdy, e_we;
        logic [10:0] e_addr;
        logic [7:0] e_wd, nxt_rd;
        logic rd_upd;
        c = k % DIV;
        if (k == cpu_due) m_crd = cpu_val;
        if (k == h_ack && !h_we) m_hrd = h_val;
        e_busy = (k > h_lat) && (k <= h_ack);
        e_ack  = (k == h_ack);
        hacc   = (k == h_acc);
        cacc   = (c == DIV - 1) && cpu_sel && !cpu_halt;
        e_rdy  = hacc || cacc;
        e_we   = hacc ? h_we : (cacc && cpu_we);
        e_addr = hacc ? h_addr : cpu_addr;
        e_wd   = hacc ? h_wd : cpu_wdata;
        #2;
        chk("slow_clock", slow_clock, c == DIV - 1);
        chk("cpu_rdy", cpu_rdy, (c == DIV - 1) && !cpu_halt);
        chk("io_rdy", io_rdy, e_rdy);
        chk("io_we", io_we, e_we);
        chk("io_addr", io_addr, e_addr);
        chk("io_wdata", io_wdata, e_wd);
        chk("host_busy", host_busy, e_busy);
        chk("host_ack", host_ack, e_ack);
        chk("host_rdata", host_rdata, m_hrd);
        chk("cpu_rdata", cpu_rdata, m_crd);
        s_c = c;
        s_io_rdy = io_rdy; s_io_we = io_we; s_ack = host_ack;
        s_io_addr = io_addr; s_io_wdata = io_wdata;
        s_cpu_rdata = cpu_rdata; s_host_rdata = host_rdata;
        if (slow_clock === 1'b1) n_slow++;
        if (cpu_rdy === 1'b1) n_crdy++;
        if (io_rdy === 1'b1) n_iordy++;
        if (host_ack === 1'b1) n_ack++;
        if (host_busy === 1'b1) n_busy++;
        // I/O block: registered read, write on strobe
        rd_upd = 1'b0;
        nxt_rd = io_rdata;
        if (io_rdy === 1'b1) begin
            if (io_we) iomem[io_addr] = io_wdata;
            else begin
                nxt_rd = iomem[io_addr];
                rd_upd = 1'b1;
            end
        end
        // Model effects of this cycle
        if (hacc) begin
            if (h_we) refmem[h_addr] = h_wd;
            else h_val = refmem[h_addr];
        end else if (cacc) begin
            if (cpu_we) refmem[cpu_addr] = cpu_wdata;
            else begin
                cpu_due = k + 2;
                cpu_val = refmem[cpu_addr];
            end
        end
        if (!e_busy && host_req) begin
            h_lat  = k;
            h_we   = host_we;
            h_addr = host_addr;
            h_wd   = host_wdata;
            h_acc  = k + 1 + ((HS - ((k + 1) % DIV) + DIV) % DIV);
            h_ack  = h_acc + 1;
        end
        @(posedge clk);
        #1;
        if (rd_upd) io_rdata = nxt_rd;
        k++;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        chk("rst cpu_rdy", cpu_rdy, 0);
        chk("rst slow_clock", slow_clock, 0);
        chk("rst host_ack", host_ack, 0);
        chk("rst host_busy", host_busy, 0);
        chk("rst io_rdy", io_rdy, 0);
        chk("rst io_we", io_we, 0);
        chk("rst cpu_rdata", cpu_rdata, 0);
        chk("rst host_rdata", host_rdata, 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0;
        model_reset();
    endtask

    task automatic goto_c(input int c);
        for (int i = 0; i < DIV && (k % DIV) != c; i++) run_cycle();
    endtask

    initial begin
        int first_slow;
        int ack_c, io_c;
        logic [10:0] io_a;
        bit seen;
        for (int i = 0; i < 2048; i++) begin
            iomem[i]  = 8'($urandom);
            refmem[i] = iomem[i];
        end
        set_idle();
        model_reset();
        #1;
        do_reset();

        // Idle: pulse cadence and no I/O traffic
        zero_counts();
        first_slow = -1;
        for (int i = 0; i < 80; i++) begin
            run_cycle();
            if (first_slow < 0 && n_slow == 1) first_slow = k - 1;
        end
        chk("idle slow pulses", n_slow, 10);
        chk("idle cpu_rdy pulses", n_crdy, 10);
        chk("idle io_rdy", n_iordy, 0);
        chk("first slow pulse", first_slow, 7);

        // CPU write
        goto_c(7);
        cpu_sel = 1; cpu_we = 1; cpu_addr = 11'h010; cpu_wdata = 8'h3C;
        run_cycle();
        chk("cw io_rdy", s_io_rdy, 1);
        chk("cw io_we", s_io_we, 1);
        chk("cw io_addr", s_io_addr, 11'h010);
        chk("cw io_wdata", s_io_wdata, 8'h3C);
        set_idle();
        run_cycle();
        chk("cw one clock", s_io_rdy, 0);

        // CPU read
        iomem[11'h012] = 8'hA5; refmem[11'h012] = 8'hA5;
        goto_c(7);
        cpu_sel = 1; cpu_we = 0; cpu_addr = 11'h012;
        run_cycle();
        set_idle();
        run_cycle();
        run_cycle();
        chk("cr rdata", s_cpu_rdata, 8'hA5);
        goto_c(6);
        run_cycle();
        chk("cr held", s_cpu_rdata, 8'hA5);

        // Host read at cnt=0
        iomem[11'h040] = 8'h5A; refmem[11'h040] = 8'h5A;
        goto_c(0);
        host_req = 1; host_we = 0; host_addr = 11'h040;
        run_cycle();
        host_req = 0;
        zero_counts();
        seen = 0; ack_c = -1; io_c = -1; io_a = '0;
        for (int i = 0; i < DIV + 2 && !seen; i++) begin
            run_cycle();
            if (s_io_rdy) begin io_c = s_c; io_a = s_io_addr; end
            if (s_ack) begin
                seen = 1; ack_c = s_c;
                chk("hr rdata", s_host_rdata, 8'h5A);
            end
        end
        chk("hr ack seen", seen, 1);
        chk("hr ack cnt", ack_c, 5);
        chk("hr io cnt", io_c, 4);
        chk("hr io addr", io_a, 11'h040);
        chk("hr busy clocks", n_busy, 5);

        // Halted CPU with pending read plus host write
        goto_c(0);
        cpu_halt = 1; cpu_sel = 1; cpu_we = 0; cpu_addr = 11'h033;
        host_req = 1; host_we = 1; host_addr = 11'h020;
        host_wdata = 8'hFF;
        run_cycle();
        host_req = 0;
        zero_counts();
        for (int i = 0; i < DIV; i++) run_cycle();
        chk("halt cpu_rdy", n_crdy, 0);
        chk("halt slow", n_slow, 1);
        chk("halt io_rdy", n_iordy, 1);
        chk("halt ack", n_ack, 1);
        chk("halt host write", iomem[11'h020], 8'hFF);
        set_idle();

        // Reset while host request pending
        goto_c(0);
        host_req = 1; host_we = 0; host_addr = 11'h055;
        run_cycle();
        host_req = 0;
        run_cycle();
        chk("pre-reset busy", host_busy, 1);
        do_reset();
        zero_counts();
        host_req = 1; host_we = 0; host_addr = 11'h040;
        run_cycle();
        host_req = 0;
        for (int i = 0; i < DIV; i++) begin
            run_cycle();
            if (s_ack) chk("post-reset rdata", s_host_rdata, 8'h5A);
        end
        chk("post-reset acks", n_ack, 1);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            cpu_sel    = 1'($urandom % 2);
            cpu_we     = 1'($urandom % 2);
            cpu_addr   = 11'($urandom_range(0, 2047));
            cpu_wdata  = 8'($urandom);
            cpu_halt   = ($urandom % 8) == 0;
            host_req   = ($urandom % 3) == 0;
            host_we    = 1'($urandom % 2);
            host_addr  = 11'($urandom_range(0, 2047));
            host_wdata = 8'($urandom);
            if (i == 1500) do_reset();
            else run_cycle();
        end
        set_idle();
        run_cycle();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
